axi_burst_mem_slave: RTL and testbench
======================================

Name: axi_burst_mem_slave

Overview:
- AXI4 burst responder (slave) backed by an on-chip word memory.
- It is the far end of the simplified AXI4 master channel set the kernel wrappers drive (aw/w/b and ar/r, no IDs, INCR bursts only).
- Used as the on-chip DDR stand-in for kernel-level simulation and as a local scratch buffer behind the kernel's AXI read/write masters.
- Serves one burst at a time on a single-port memory.

Parameters:
- C_S_AXI_ADDR_WIDTH, 64, byte address width.
- C_S_AXI_DATA_WIDTH, 512, data beat width; power of two, ≥32.
- C_MEM_DEPTH, 512, memory depth in beats; power of two.

Ports:
- aclk  in  1  sole clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address accepted.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data accepted.
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write beat.
- s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid  out  1  write response valid; response is always OKAY, so there is no bresp port.
- s_axi_bready  in  1  response accepted.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address accepted.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  beats-1.
- s_axi_rvalid  out  1  read beat valid.
- s_axi_rready  in  1  read beat accepted.
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read beat.
- s_axi_rlast  out  1  final read beat.

Behaviour:
- Reset, asynchronous on aresetn low:
  - All ready/valid outputs = 0.
  - rdata = 0, rlast = 0.
  - FSM = IDLE, beat counters = 0, arbitration pointer = write-first.
  - Memory contents are not reset.
  - Reset asserted mid-burst abandons the burst. No beats or responses are emitted afterwards.
- Word index = addr[LOG_BYTES +: LOG_DEPTH], where LOG_BYTES = log2(DW/8) and LOG_DEPTH = log2(C_MEM_DEPTH).
  - Low byte-offset bits and high bits are ignored.
  - The index increments per beat and wraps modulo C_MEM_DEPTH.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - awready = (awvalid && grant_wr), arready = (arvalid && grant_rd), registered for one cycle, so a handshake occurs on the cycle after valid is seen.
  - If only one valid is high, that one is granted.
  - If both are high, use round-robin: the pointer toggles after each accepted burst. Post-reset, write wins.
  - On aw handshake: latch index and len, go to WR_DATA.
  - On ar handshake: latch index and len, go to RD_DATA.
- WR_DATA:
  - wready = 1.
  - Each wvalid&&wready beat writes the strobed bytes to mem[idx], then idx++ and count++.
  - On the beat where count == len: go to WR_RESP, wready drops the next cycle.
  - Burst end is determined by awlen; wlast is not used for termination.
- WR_RESP:
  - bvalid = 1 is held until bready, then return to IDLE with bvalid = 0.
  - The first bvalid comes no earlier than the cycle after the last w beat.
- RD_DATA:
  - Synchronous memory read, registered output.
  - First rvalid appears 2 cycles after the ar handshake.
  - Throughput is 1 beat/cycle while rready = 1.
  - While rvalid && !rready, rdata and rlast hold stable and no further memory read is consumed. A prefetch skid entry is permitted.
  - rlast = 1 exactly on beat len.
  - After the last beat's handshake: go to IDLE with rvalid = 0 the next cycle.
- A read of a just-written address in the next burst returns the new data (no bypass required, since bursts are serialized).
- len = 0 gives a single beat with rlast = 1 on it and a single bresp.
- len = 255 at index C_MEM_DEPTH-3 wraps to index 0 without error.

Optional Feature:
- Macro: AXI_BURST_MEM_SLAVE_LAST_CHECK_EN.
- When defined:
  - Adds output port wlast_err (1 bit, reset 0).
  - wlast_err is sticky-set when a w beat has wlast != (count == len), and is cleared only by reset.
  - Simulation $error on the same condition.
- When undefined: no port and no logic; wlast is ignored.

Decomposition:
- Shared package axi_mem_pkg containing:
  - typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} mem_state_t.
  - Functions for LOG_BYTES and LOG_DEPTH derivation.
  - localparam LP_AXI_LEN_W = 8.
- One natural sub-module: axi_burst_mem_ram. It is a single-port byte-enabled RAM with a registered read and no reset on data, inferred as BRAM.

Test Plan:
- Write burst addr 0x0, awlen 3, data 0xA0..0xA3, wstrb all-1 → 4 beats accepted, 1 bvalid. Then read addr 0x0, arlen 3 → rdata 0xA0..0xA3, rlast only on the 4th beat.
- Partial strobe: write 0xFFFF… to word 5, then write 0x11… with wstrb = 0x1 → read of word 5 returns low byte 0x11, all other bytes 0xFF.
- Backpressure: read of 8 beats with rready toggling 1,0,0,1,… → no beat lost or duplicated, rdata stable during stalls, exactly 8 handshakes.
- Wrap: with DW = 512, write awaddr = (C_MEM_DEPTH-2)*64, awlen 3 → beats land in words 510, 511, 0, 1, and readback matches.
- Arbitration: awvalid and arvalid both asserted from reset → write served first, then read. Repeated simultaneous requests alternate between write and read.
- With AXI_BURST_MEM_SLAVE_LAST_CHECK_EN defined: awlen 3 with wlast on beat 2 → wlast_err = 1 from the next cycle, and it remains 1 until aresetn is asserted low.

Source files
------------

// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared types and helpers for the AXI4 burst memory slave (axi_burst_mem_slave).
// Optional wlast consistency checking is enabled by AXI_BURST_MEM_SLAVE_LAST_CHECK_EN.
package axi_mem_pkg;

   localparam int LP_AXI_LEN_W = 8;

   typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} mem_state_t;

   function automatic int f_log_bytes(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int f_log_depth(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// Simplified AXI4 channel bundle (aw/w/b, ar/r; no IDs, INCR only).
// Handshakes: a transfer occurs on a rising edge where valid && ready; a source holds valid and payload until it sees ready.
interface axi_burst_mem_slave_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   logic                                 s_axi_awvalid;
   logic                                 s_axi_awready;
   logic [ADDR_W-1:0]                    s_axi_awaddr;
   logic [axi_mem_pkg::LP_AXI_LEN_W-1:0] s_axi_awlen;
   logic                                 s_axi_wvalid;
   logic                                 s_axi_wready;
   logic [DATA_W-1:0]                    s_axi_wdata;
   logic [DATA_W/8-1:0]                  s_axi_wstrb;
   logic                                 s_axi_wlast;
   logic                                 s_axi_bvalid;
   logic                                 s_axi_bready;
   logic                                 s_axi_arvalid;
   logic                                 s_axi_arready;
   logic [ADDR_W-1:0]                    s_axi_araddr;
   logic [axi_mem_pkg::LP_AXI_LEN_W-1:0] s_axi_arlen;
   logic                                 s_axi_rvalid;
   logic                                 s_axi_rready;
   logic [DATA_W-1:0]                    s_axi_rdata;
   logic                                 s_axi_rlast;

   modport slave (
      input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
      input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      input  s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
      output s_axi_rvalid, s_axi_rdata, s_axi_rlast
   );

   modport master (
      output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
      output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      output s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
      input  s_axi_rvalid, s_axi_rdata, s_axi_rlast
   );

endinterface

// File: rtl/axi_burst_mem_ram.sv
// Single-port byte-enabled RAM with registered read; data is not reset so it maps onto block RAM.
module axi_burst_mem_ram #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 512
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [DATA_W/8-1:0]      be,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      // Without re the output holds, which doubles as the read-side skid entry.
      if (re) rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR burst slave over a single-port word memory, one burst at a time, round-robin aw/ar.
// Define AXI_BURST_MEM_SLAVE_LAST_CHECK_EN to add the sticky wlast_err output.
module axi_burst_mem_slave
   import axi_mem_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 64,
   parameter int C_S_AXI_DATA_WIDTH = 512,
   parameter int C_MEM_DEPTH        = 512
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axi_burst_mem_slave_if.slave  s,
   output mem_state_t            dbg_state
`ifdef AXI_BURST_MEM_SLAVE_LAST_CHECK_EN
   ,
   output logic                  wlast_err
`endif
);
   localparam int LOG_BYTES = f_log_bytes(C_S_AXI_DATA_WIDTH);
   localparam int LOG_DEPTH = f_log_depth(C_MEM_DEPTH);
   localparam int DW        = C_S_AXI_DATA_WIDTH;

   mem_state_t              state_q, state_d;
   logic [LOG_DEPTH-1:0]    idx_q, idx_d;
   logic [LP_AXI_LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic                    wr_prio_q, wr_prio_d;
   logic                    awready_q, awready_d, arready_q, arready_d;
   logic                    rd_issued_q, rd_issued_d;
   logic                    ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
   logic                    rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [DW-1:0]           rdata_q, rdata_d;
   logic                    grant_wr, grant_rd, last_beat, w_beat, out_load, rd_issue;
   logic [DW-1:0]           ram_rdata;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      wr_prio_d   = wr_prio_q;
      awready_d   = 1'b0;
      arready_d   = 1'b0;
      rd_issued_d = rd_issued_q;
      ram_vld_d   = ram_vld_q;
      ram_last_d  = ram_last_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      rdata_d     = rdata_q;

      grant_wr  = s.s_axi_awvalid && (!s.s_axi_arvalid || wr_prio_q);
      grant_rd  = s.s_axi_arvalid && !grant_wr;
      last_beat = (cnt_q == len_q);
      w_beat    = (state_q == WR_DATA) && s.s_axi_wvalid;
      // ram_vld_q marks a fetched beat waiting in the RAM output register.
      out_load  = ram_vld_q && (!rvalid_q || s.s_axi_rready);
      rd_issue  = (state_q == RD_DATA) && !rd_issued_q && (!ram_vld_q || out_load);

      unique case (state_q)
         IDLE: begin
            if (awready_q && s.s_axi_awvalid) begin
               state_d   = WR_DATA;
               idx_d     = s.s_axi_awaddr[LOG_BYTES +: LOG_DEPTH];
               len_d     = s.s_axi_awlen;
               cnt_d     = '0;
               wr_prio_d = 1'b0;
            end else if (arready_q && s.s_axi_arvalid) begin
               state_d     = RD_DATA;
               idx_d       = s.s_axi_araddr[LOG_BYTES +: LOG_DEPTH];
               len_d       = s.s_axi_arlen;
               cnt_d       = '0;
               wr_prio_d   = 1'b1;
               rd_issued_d = 1'b0;
            end else begin
               awready_d = grant_wr;
               arready_d = grant_rd;
            end
         end
         WR_DATA: begin
            if (w_beat) begin
               idx_d = idx_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (last_beat) state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (s.s_axi_bready) state_d = IDLE;
         end
         RD_DATA: begin
            if (rd_issue) begin
               idx_d = idx_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (last_beat) rd_issued_d = 1'b1;
            end
            if (rvalid_q && s.s_axi_rready && rlast_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rd_issue) begin
         ram_vld_d  = 1'b1;
         ram_last_d = last_beat;
      end else if (out_load) begin
         ram_vld_d  = 1'b0;
      end

      if (out_load) begin
         rvalid_d = 1'b1;
         rdata_d  = ram_rdata;
         rlast_d  = ram_last_q;
      end else if (rvalid_q && s.s_axi_rready) begin
         rvalid_d = 1'b0;
         rlast_d  = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         wr_prio_q   <= 1'b1;
         awready_q   <= 1'b0;
         arready_q   <= 1'b0;
         rd_issued_q <= 1'b0;
         ram_vld_q   <= 1'b0;
         ram_last_q  <= 1'b0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         wr_prio_q   <= wr_prio_d;
         awready_q   <= awready_d;
         arready_q   <= arready_d;
         rd_issued_q <= rd_issued_d;
         ram_vld_q   <= ram_vld_d;
         ram_last_q  <= ram_last_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
         rdata_q     <= rdata_d;
      end
   end

   axi_burst_mem_ram #(.DATA_W(DW), .DEPTH(C_MEM_DEPTH)) u_ram (
      .clk   (aclk),
      .we    (w_beat),
      .be    (s.s_axi_wstrb),
      .re    (rd_issue),
      .addr  (idx_q),
      .wdata (s.s_axi_wdata),
      .rdata (ram_rdata)
   );

   assign s.s_axi_awready = awready_q;
   assign s.s_axi_arready = arready_q;
   assign s.s_axi_wready  = (state_q == WR_DATA);
   assign s.s_axi_bvalid  = (state_q == WR_RESP);
   assign s.s_axi_rvalid  = rvalid_q;
   assign s.s_axi_rdata   = rdata_q;
   assign s.s_axi_rlast   = rlast_q;
   assign dbg_state       = state_q;

   // Byte-offset and above-depth address bits carry no meaning here.
   logic unused_addr;
   assign unused_addr = ^{s.s_axi_awaddr, s.s_axi_araddr};

`ifdef AXI_BURST_MEM_SLAVE_LAST_CHECK_EN
   logic wlast_err_q, wlast_err_d;

   always_comb begin
      wlast_err_d = wlast_err_q;
      if (w_beat && (s.s_axi_wlast != last_beat)) wlast_err_d = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) wlast_err_q <= 1'b0;
      else          wlast_err_q <= wlast_err_d;
   end

   always @(posedge aclk) begin
      if (aresetn && w_beat && (s.s_axi_wlast != last_beat))
         $error("axi_burst_mem_slave: wlast=%0b on beat %0d of awlen %0d", s.s_axi_wlast, cnt_q, len_q);
   end

   assign wlast_err = wlast_err_q;
`else
   logic unused_wlast;
   assign unused_wlast = s.s_axi_wlast;
`endif

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed-plus-random bench for axi_burst_mem_slave against a byte-level memory model.
module tb_axi_burst_mem_slave;
   import axi_mem_pkg::*;

   localparam int AW    = 64;
   localparam int DW    = 512;
   localparam int DEPTH = 512;
   localparam int BPB   = DW / 8;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   mem_state_t dbg_state;
`ifdef AXI_BURST_MEM_SLAVE_LAST_CHECK_EN
   logic       wlast_err;
`endif

   axi_burst_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   axi_burst_mem_slave #(
      .C_S_AXI_ADDR_WIDTH (AW),
      .C_S_AXI_DATA_WIDTH (DW),
      .C_MEM_DEPTH        (DEPTH)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s         (bus.slave),
      .dbg_state (dbg_state)
`ifdef AXI_BURST_MEM_SLAVE_LAST_CHECK_EN
      ,
      .wlast_err (wlast_err)
`endif
   );

   // clock / reset
   always #5 aclk = ~aclk;
   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   int                tests_run = 0;
   int                tests_failed = 0;
   int                last_hs_cyc = 0;
   logic [DW-1:0]     mem_m [DEPTH];
   logic [DW-1:0]     wdata_q [$];
   logic [BPB-1:0]    wstrb_q [$];
   logic [DW-1:0]     last_rdata;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [AW-1:0] a);
      return int'((a / BPB) % DEPTH);
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [BPB-1:0] st);
      for (int b = 0; b < BPB; b++) if (st[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
   endtask

   // mode 0: full strobes, 1: random strobes
   task automatic push_beats(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         wdata_q.push_back(rand_word());
         wstrb_q.push_back(mode == 0 ? {BPB{1'b1}} : {$urandom(), $urandom()});
      end
   endtask

   function automatic logic rr_pick(input int mode, input int p);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (p % 4 == 0) || (p % 4 == 3);
      return 1'(($urandom() >> 3) & 1);
   endfunction

   // driver tasks
   task automatic idle_inputs();
      bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
      bus.s_axi_wvalid  = 1'b0; bus.s_axi_wdata  = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
      bus.s_axi_bready  = 1'b0;
      bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
      bus.s_axi_rready  = 1'b0;
   endtask

   task automatic wait_aw_hs();
      int n = 0;
      bit ok = 0;
      while (!ok && n < 50) begin
         @(negedge aclk); n++;
         ok = bus.s_axi_awready;
      end
      check("aw_handshake", ok, 1'b1);
      @(posedge aclk); #1;
      bus.s_axi_awvalid = 1'b0;
      last_hs_cyc = cyc;
   endtask

   task automatic wait_ar_hs();
      int n = 0;
      bit ok = 0;
      while (!ok && n < 50) begin
         @(negedge aclk); n++;
         ok = bus.s_axi_arready;
      end
      check("ar_handshake", ok, 1'b1);
      @(posedge aclk); #1;
      bus.s_axi_arvalid = 1'b0;
      last_hs_cyc = cyc;
   endtask

   // both valids already driven: report which side is granted first
   task automatic arb_wait(output bit wr_first);
      int n = 0;
      bit ok = 0;
      wr_first = 1'b0;
      while (!ok && n < 50) begin
         @(negedge aclk); n++;
         ok = bus.s_axi_awready || bus.s_axi_arready;
      end
      check("arb_grant_seen", ok, 1'b1);
      check("arb_single_grant", bus.s_axi_awready && bus.s_axi_arready, 1'b0);
      wr_first = bus.s_axi_awready;
      @(posedge aclk); #1;
      if (wr_first) bus.s_axi_awvalid = 1'b0;
      else          bus.s_axi_arvalid = 1'b0;
      last_hs_cyc = cyc;
   endtask

   task automatic write_burst(input logic [AW-1:0] addr, input int len, input int bad_last);
      int  idx0 = idx_of(addr);
      int  n;
      bit  ok, got;
      for (int i = 0; i <= len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.s_axi_wvalid = 1'b0;
            @(posedge aclk); #1;
         end
         bus.s_axi_wvalid = 1'b1;
         bus.s_axi_wdata  = wdata_q.pop_front();
         bus.s_axi_wstrb  = wstrb_q.pop_front();
         bus.s_axi_wlast  = (bad_last >= 0) ? (i == bad_last) : (i == len);
         n = 0; ok = 0;
         while (!ok && n < 50) begin
            @(negedge aclk); n++;
            ok = bus.s_axi_wready;
            if (!ok) begin @(posedge aclk); #1; end
         end
         check("w_beat_accepted", ok, 1'b1);
         check("b_not_before_last", bus.s_axi_bvalid, 1'b0);
         if (!ok) break;
         model_write((idx0 + i) % DEPTH, bus.s_axi_wdata, bus.s_axi_wstrb);
         @(posedge aclk); #1;
      end
      bus.s_axi_wvalid = 1'b0;
      bus.s_axi_wlast  = 1'b0;
      n = 0; got = 0;
      bus.s_axi_bready = 1'($urandom_range(0, 1));
      while (!got && n < 100) begin
         @(negedge aclk); n++;
         if (n == 1) check("wready_drops", bus.s_axi_wready, 1'b0);
         got = bus.s_axi_bvalid && bus.s_axi_bready;
         @(posedge aclk); #1;
         if (!got) bus.s_axi_bready = 1'($urandom_range(0, 1));
      end
      bus.s_axi_bready = 1'b0;
      check("b_handshake", got, 1'b1);
      @(negedge aclk);
      check("b_single", bus.s_axi_bvalid, 1'b0);
      check("state_idle_after_b", dbg_state, IDLE);
   endtask

   task automatic read_burst(input logic [AW-1:0] addr, input int len, input int mode);
      int            idx0 = idx_of(addr);
      int            k = 0, p = 0, budget = 0;
      bit            first = 1, stalled = 0;
      logic [DW-1:0] held_d;
      logic          held_l = 1'b0;
      held_d = '0;
      bus.s_axi_rready = rr_pick(mode, p);
      while (k <= len && budget < 3000) begin
         @(negedge aclk); budget++;
         if (stalled) begin
            check("rd_hold_valid", bus.s_axi_rvalid, 1'b1);
            check("rd_hold_data", bus.s_axi_rdata, held_d);
            check("rd_hold_last", bus.s_axi_rlast, held_l);
         end
         if (bus.s_axi_rvalid) begin
            if (first) begin
               check("rd_first_latency", cyc - last_hs_cyc, 2);
               first = 0;
            end
            if (bus.s_axi_rready) begin
               check("rd_data", bus.s_axi_rdata, mem_m[(idx0 + k) % DEPTH]);
               check("rd_last", bus.s_axi_rlast, (k == len));
               last_rdata = bus.s_axi_rdata;
               k++;
               stalled = 0;
            end else begin
               stalled = 1;
               held_d  = bus.s_axi_rdata;
               held_l  = bus.s_axi_rlast;
            end
         end
         @(posedge aclk); #1;
         p++;
         bus.s_axi_rready = rr_pick(mode, p);
      end
      check("rd_beat_count", k, len + 1);
      @(negedge aclk);
      check("rd_no_extra_beat", bus.s_axi_rvalid, 1'b0);
      bus.s_axi_rready = 1'b0;
   endtask

   task automatic write_txn(input logic [AW-1:0] addr, input int len, input int bad_last);
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_awaddr  = addr;
      bus.s_axi_awlen   = 8'(len);
      wait_aw_hs();
      write_burst(addr, len, bad_last);
   endtask

   task automatic read_txn(input logic [AW-1:0] addr, input int len, input int mode);
      bus.s_axi_arvalid = 1'b1;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arlen   = 8'(len);
      wait_ar_hs();
      read_burst(addr, len, mode);
   endtask

   task automatic serve_pair(input bit wr_first, input logic [AW-1:0] wa, input int wl,
                             input logic [AW-1:0] ra, input int rl);
      if (wr_first) begin
         write_burst(wa, wl, -1);
         wait_ar_hs();
         read_burst(ra, rl, 0);
      end else begin
         read_burst(ra, rl, 0);
         wait_aw_hs();
         write_burst(wa, wl, -1);
      end
   endtask

   // directed sequence
   initial begin
      bit            wf;
      bit            noisy;
      logic [AW-1:0] a;
      logic [DW-1:0] exp_part;
      int            l;

      idle_inputs();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_awready", bus.s_axi_awready, 1'b0);
      check("rst_arready", bus.s_axi_arready, 1'b0);
      check("rst_wready", bus.s_axi_wready, 1'b0);
      check("rst_bvalid", bus.s_axi_bvalid, 1'b0);
      check("rst_rvalid", bus.s_axi_rvalid, 1'b0);
      check("rst_rdata", bus.s_axi_rdata, '0);
      check("rst_rlast", bus.s_axi_rlast, 1'b0);
      check("rst_state", dbg_state, IDLE);

      // simultaneous requests straight out of reset: write wins, then read
      for (int i = 0; i < 4; i++) begin
         wdata_q.push_back(DW'(8'hA0 + i));
         wstrb_q.push_back({BPB{1'b1}});
      end
      bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = '0; bus.s_axi_awlen = 8'd3;
      bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = '0; bus.s_axi_arlen = 8'd3;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      arb_wait(wf);
      check("arb1_write_first", wf, 1'b1);
      serve_pair(wf, '0, 3, '0, 3);
      check("basic_last_beat_a3", last_rdata, DW'(8'hA3));

      // second simultaneous pair, single-beat bursts, read of the just-written word
      a = AW'($urandom_range(0, DEPTH - 1)) * BPB;
      push_beats(1, 0);
      bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = a; bus.s_axi_awlen = 8'd0;
      bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = a; bus.s_axi_arlen = 8'd0;
      arb_wait(wf);
      check("arb2_write_first", wf, 1'b1);
      serve_pair(wf, a, 0, a, 0);

      // fill the whole memory so every later strobe pattern has a known background
      push_beats(256, 0);
      write_txn('0, 255, -1);
      push_beats(256, 0);
      write_txn(AW'(256 * BPB), 255, -1);

      // partial strobe on word 5
      wdata_q.push_back({DW{1'b1}});
      wstrb_q.push_back({BPB{1'b1}});
      write_txn(AW'(5 * BPB), 0, -1);
      wdata_q.push_back({(DW / 8){8'h11}});
      wstrb_q.push_back(BPB'(1));
      write_txn(AW'(5 * BPB), 0, -1);
      read_txn(AW'(5 * BPB), 0, 0);
      exp_part = {{(BPB - 1){8'hFF}}, 8'h11};
      check("partial_strobe_word5", last_rdata, exp_part);

      // read backpressure with rready 1,0,0,1,...
      push_beats(8, 1);
      write_txn(AW'(64 * BPB), 7, -1);
      read_txn(AW'(64 * BPB), 7, 1);

      // wrap from the top of memory
      push_beats(4, 0);
      write_txn(AW'((DEPTH - 2) * BPB), 3, -1);
      read_txn('0, 1, 0);
      read_txn(AW'((DEPTH - 2) * BPB), 3, 2);

      // longest burst starting three words from the top
      push_beats(256, 1);
      write_txn(AW'((DEPTH - 3) * BPB), 255, -1);
      read_txn(AW'((DEPTH - 3) * BPB), 255, 2);

      // random bursts with junk in offset and high address bits
      for (int t = 0; t < 4; t++) begin
         a = {$urandom(), $urandom()};
         l = $urandom_range(0, 15);
         push_beats(l + 1, 1);
         write_txn(a, l, -1);
         read_txn(a, l, 2);
      end

      // reset in the middle of a read burst
      bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = AW'(64 * BPB); bus.s_axi_arlen = 8'd15;
      wait_ar_hs();
      bus.s_axi_rready = 1'b1;
      repeat (4) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check("midrst_rvalid", bus.s_axi_rvalid, 1'b0);
      check("midrst_rdata", bus.s_axi_rdata, '0);
      check("midrst_rlast", bus.s_axi_rlast, 1'b0);
      check("midrst_state", dbg_state, IDLE);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      noisy = 0;
      repeat (6) begin
         @(negedge aclk);
         noisy = noisy | bus.s_axi_rvalid | bus.s_axi_bvalid | bus.s_axi_wready;
      end
      check("midrst_quiet_after", noisy, 1'b0);
      bus.s_axi_rready = 1'b0;
      read_txn(AW'(64 * BPB), 7, 0);

`ifdef AXI_BURST_MEM_SLAVE_LAST_CHECK_EN
      @(negedge aclk);
      check("wlast_err_clear", wlast_err, 1'b0);
      push_beats(4, 0);
      write_txn('0, 3, 2);
      check("wlast_err_set", wlast_err, 1'b1);
      repeat (5) @(negedge aclk);
      check("wlast_err_sticky", wlast_err, 1'b1);
      aresetn = 1'b0;
      #1;
      check("wlast_err_reset", wlast_err, 1'b0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
